// File: rtl/motor_arming_failsafe.sv
// motor_arming_failsafe
//   Safety gate between the motor mixer and the PWM generator. Motor rates are
//   passed through only while ARMED. Arming needs the arm switch, low throttle,
//   a good IMU and a live receiver held for ARM_HOLD_US cycles. Losing the
//   receiver or the IMU while armed ramps all motors to zero and then locks out
//   until the pilot turns the arm switch off.
//
// Ports
//   us_clk                      1 MHz clock (only clock)
//   resetn                      synchronous active-low reset
//   motor_N_rate_in  (N=1..4)   rates from the mixer
//   throttle_val                receiver throttle value
//   arm_switch                  1 = arm requested
//   rx_pulse                    raw receiver PWM (asynchronous)
//   imu_good                    IMU ready
//   motor_N_rate_out (N=1..4)   gated rates to the PWM generator
//   armed                       high only in ARMED
//   failsafe_active             high in RAMP and LOCKOUT
//   signal_ok                   receiver link alive
//   state                       current FSM state (debug)
module motor_arming_failsafe #(
  parameter int unsigned RATE_WIDTH       = 8,
  parameter int unsigned ARM_HOLD_US      = 500000,
  parameter int unsigned LOSS_TIMEOUT_US  = 100000,
  parameter int unsigned RAMP_STEP_US     = 10000,
  parameter int unsigned THROTTLE_ARM_MAX = 10
) (
  input  logic                  us_clk,
  input  logic                  resetn,
  input  logic [RATE_WIDTH-1:0] motor_1_rate_in,
  input  logic [RATE_WIDTH-1:0] motor_2_rate_in,
  input  logic [RATE_WIDTH-1:0] motor_3_rate_in,
  input  logic [RATE_WIDTH-1:0] motor_4_rate_in,
  input  logic [7:0]            throttle_val,
  input  logic                  arm_switch,
  input  logic                  rx_pulse,
  input  logic                  imu_good,
  output logic [RATE_WIDTH-1:0] motor_1_rate_out,
  output logic [RATE_WIDTH-1:0] motor_2_rate_out,
  output logic [RATE_WIDTH-1:0] motor_3_rate_out,
  output logic [RATE_WIDTH-1:0] motor_4_rate_out,
  output logic                  armed,
  output logic                  failsafe_active,
  output logic                  signal_ok,
  output logic [2:0]            state
);

  localparam int unsigned HOLD_W = $clog2(ARM_HOLD_US + 1);
  localparam int unsigned RAMP_W = $clog2(RAMP_STEP_US + 1);
  localparam int unsigned WD_W   = $clog2(LOSS_TIMEOUT_US + 1);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARM_WAIT = 3'd1,
    ARMED    = 3'd2,
    RAMP     = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [3:0][RATE_WIDTH-1:0] rate_q, rate_d, rate_in;
  logic armed_q, fs_q;

  // Synchronizer (s1, s2) plus one delay flop for rising-edge detection.
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic rx_rise;
  logic arm_cond;

  assign rate_in  = {motor_4_rate_in, motor_3_rate_in, motor_2_rate_in, motor_1_rate_in};
  assign rx_rise  = rx_s2_q & ~rx_s3_q;
  assign signal_ok = (wd_q < WD_W'(LOSS_TIMEOUT_US));
  assign arm_cond = arm_switch & signal_ok & imu_good &
                    (throttle_val <= 8'(THROTTLE_ARM_MAX));

  // Receiver watchdog: cleared by an edge, otherwise counts up and saturates.
  always_comb begin
    wd_d = wd_q;
    if (rx_rise) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(LOSS_TIMEOUT_US)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ramp_d  = ramp_q;
    rate_d  = '0;
    case (state_q)
      DISARMED: begin
        if (arm_cond) begin
          state_d = ARM_WAIT;
          hold_d  = '0;
        end
      end
      ARM_WAIT: begin
        if (!arm_cond) begin
          state_d = DISARMED;
        end else if (hold_q == HOLD_W'(ARM_HOLD_US - 1)) begin
          state_d = ARMED;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ARMED: begin
        // Switch-off disarm takes priority over failsafe entry.
        if (!arm_switch) begin
          state_d = DISARMED;
        end else if (!signal_ok || !imu_good) begin
          state_d = RAMP;
          rate_d  = rate_q;
          ramp_d  = '0;
        end else begin
          rate_d = rate_in;
        end
      end
      RAMP: begin
        if (!arm_switch) begin
          state_d = DISARMED;
        end else if (rate_q == '0) begin
          state_d = LOCKOUT;
        end else begin
          rate_d = rate_q;
          if (ramp_q == RAMP_W'(RAMP_STEP_US - 1)) begin
            ramp_d = '0;
            for (int unsigned i = 0; i < 4; i++) begin
              if (rate_q[i] != '0) begin
                rate_d[i] = rate_q[i] - RATE_WIDTH'(1);
              end
            end
          end else begin
            ramp_d = ramp_q + RAMP_W'(1);
          end
        end
      end
      LOCKOUT: begin
        if (!arm_switch && signal_ok) begin
          state_d = DISARMED;
        end
      end
      default: state_d = DISARMED;
    endcase
  end

  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q <= DISARMED;
      hold_q  <= '0;
      ramp_q  <= '0;
      wd_q    <= WD_W'(LOSS_TIMEOUT_US);
      rate_q  <= '0;
      armed_q <= 1'b0;
      fs_q    <= 1'b0;
      rx_s1_q <= 1'b0;
      rx_s2_q <= 1'b0;
      rx_s3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ramp_q  <= ramp_d;
      wd_q    <= wd_d;
      rate_q  <= rate_d;
      armed_q <= (state_d == ARMED);
      fs_q    <= (state_d == RAMP) || (state_d == LOCKOUT);
      rx_s1_q <= rx_pulse;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign motor_1_rate_out = rate_q[0];
  assign motor_2_rate_out = rate_q[1];
  assign motor_3_rate_out = rate_q[2];
  assign motor_4_rate_out = rate_q[3];
  assign armed            = armed_q;
  assign failsafe_active  = fs_q;
  assign state            = state_q;

endmodule

// File: tb/tb_motor_arming_failsafe.sv
module tb_motor_arming_failsafe;

  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [RW-1:0] m1_in = '0, m2_in = '0, m3_in = '0, m4_in = '0;
  logic [RW-1:0] m1_out, m2_out, m3_out, m4_out;
  logic [7:0]    throttle = 8'd5;
  logic          arm_sw = 1'b0;
  logic          rx = 1'b0;
  logic          imu = 1'b1;
  logic          armed_o, fs_o, sok_o;
  logic [2:0]    state_o;
  logic          rx_en = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  motor_arming_failsafe #(
    .RATE_WIDTH(8),
    .ARM_HOLD_US(20),
    .LOSS_TIMEOUT_US(50),
    .RAMP_STEP_US(4),
    .THROTTLE_ARM_MAX(10)
  ) dut (
    .us_clk(clk),
    .resetn(resetn),
    .motor_1_rate_in(m1_in),
    .motor_2_rate_in(m2_in),
    .motor_3_rate_in(m3_in),
    .motor_4_rate_in(m4_in),
    .throttle_val(throttle),
    .arm_switch(arm_sw),
    .rx_pulse(rx),
    .imu_good(imu),
    .motor_1_rate_out(m1_out),
    .motor_2_rate_out(m2_out),
    .motor_3_rate_out(m3_out),
    .motor_4_rate_out(m4_out),
    .armed(armed_o),
    .failsafe_active(fs_o),
    .signal_ok(sok_o),
    .state(state_o)
  );

  always #5 clk = ~clk;

  // Receiver pulse generator: toggles every 10 cycles while enabled.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rx_en) begin
        cnt++;
        if (cnt >= 10) begin
          cnt = 0;
          rx = ~rx;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      0: obs = 32'(m1_out);
      1: obs = 32'(m2_out);
      2: obs = 32'(m3_out);
      3: obs = 32'(m4_out);
      4: obs = 32'(armed_o);
      5: obs = 32'(fs_o);
      6: obs = 32'(sok_o);
      default: obs = 32'(state_o);
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_motors(input string tag, input int a, input int b, input int c, input int d);
    push({tag, ".m1"}, 0, 32'(a));
    push({tag, ".m2"}, 1, 32'(b));
    push({tag, ".m3"}, 2, 32'(c));
    push({tag, ".m4"}, 3, 32'(d));
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.sig);
      n_total++;
      assert (got === e.val) begin
        n_pass++;
      end else begin
        $error("FAIL %s got=%0d exp=%0d", e.tag, got, e.val);
      end
    end
  endtask

  // Bounded wait on a DUT signal; an expired bound fails the comparison.
  task automatic wait_for(input string tag, input int sig, input logic [31:0] val, input int maxc);
    int n;
    n = 0;
    while (obs(sig) !== val && n < maxc) begin
      tick();
      n++;
    end
    push(tag, sig, val);
    check();
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    m1_in = 8'd100; m2_in = 8'd110; m3_in = 8'd120; m4_in = 8'd130;
    tick(2);
    push_motors("reset", 0, 0, 0, 0);
    push("reset.armed", 4, 0);
    push("reset.fs", 5, 0);
    push("reset.sok", 6, 0);
    push("reset.state", 7, 0);
    check();

    // Arm sequence
    resetn = 1'b1;
    rx_en  = 1'b1;
    tick(5);
    push("pre_edge.sok", 6, 0);
    check();
    wait_for("arm.sok_up", 6, 1, 40);
    arm_sw = 1'b1;
    tick();
    push("arm.wait_entry", 7, 1);
    check();
    tick(19);
    push("arm.wait19.state", 7, 1);
    push("arm.wait19.armed", 4, 0);
    check();
    tick();
    push("arm.entry.state", 7, 2);
    push("arm.entry.armed", 4, 1);
    push_motors("arm.entry", 0, 0, 0, 0);
    check();
    tick();
    push_motors("arm.pass", 100, 110, 120, 130);
    check();
    m1_in = 8'd3; m2_in = 8'd0; m3_in = 8'd5; m4_in = 8'd2;
    tick();
    push_motors("arm.pass2", 3, 0, 5, 2);
    check();

    // Link loss and ramp
    rx_en = 1'b0;
    wait_for("loss.sok_down", 6, 0, 80);
    push("loss.still_armed", 7, 2);
    push("loss.fs_pre", 5, 0);
    check();
    m1_in = 8'd200; m2_in = 8'd200; m3_in = 8'd200; m4_in = 8'd200;
    tick();
    push("ramp.entry.state", 7, 3);
    push("ramp.entry.fs", 5, 1);
    push("ramp.entry.armed", 4, 0);
    push_motors("ramp.r0", 3, 0, 5, 2);
    check();
    tick(3);
    push_motors("ramp.r3", 3, 0, 5, 2);
    check();
    tick();
    push_motors("ramp.r4", 2, 0, 4, 1);
    check();
    tick(4);
    push_motors("ramp.r8", 1, 0, 3, 0);
    check();
    tick(4);
    push_motors("ramp.r12", 0, 0, 2, 0);
    check();
    tick(7);
    push_motors("ramp.r19", 0, 0, 1, 0);
    push("ramp.r19.state", 7, 3);
    check();
    tick();
    push_motors("ramp.r20", 0, 0, 0, 0);
    push("ramp.r20.state", 7, 3);
    push("ramp.r20.fs", 5, 1);
    check();
    tick();
    push("lockout.state", 7, 4);
    push("lockout.fs", 5, 1);
    check();

    // Lockout release
    rx_en = 1'b1;
    wait_for("lockout.sok_up", 6, 1, 40);
    tick(3);
    push("lockout.hold", 7, 4);
    check();
    arm_sw = 1'b0;
    tick();
    push("release.state", 7, 0);
    push("release.fs", 5, 0);
    push_motors("release", 0, 0, 0, 0);
    check();

    // Throttle abort during ARM_WAIT
    m1_in = 8'd100; m2_in = 8'd110; m3_in = 8'd120; m4_in = 8'd130;
    arm_sw = 1'b1;
    tick();
    push("abort.wait_entry", 7, 1);
    check();
    tick(9);
    throttle = 8'd50;
    tick();
    push("abort.state", 7, 0);
    check();
    for (int i = 0; i < 25; i++) begin
      tick();
      push("abort.armed_low", 4, 0);
      check();
    end
    push_motors("abort", 0, 0, 0, 0);
    push("abort.state_end", 7, 0);
    check();

    // Simultaneous switch-off and IMU loss
    throttle = 8'd5;
    wait_for("sim.armed", 7, 2, 40);
    tick();
    push_motors("sim.pass", 100, 110, 120, 130);
    check();
    arm_sw = 1'b0;
    imu = 1'b0;
    tick();
    push("sim.state", 7, 0);
    push("sim.fs", 5, 0);
    push("sim.armed_low", 4, 0);
    push_motors("sim", 0, 0, 0, 0);
    check();

    // Reset mid-ramp
    imu = 1'b1;
    arm_sw = 1'b1;
    wait_for("rst.armed", 7, 2, 40);
    tick();
    imu = 1'b0;
    tick();
    push("rst.ramp", 7, 3);
    push_motors("rst.ramp", 100, 110, 120, 130);
    check();
    tick(2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    push("rst.state", 7, 0);
    push("rst.sok", 6, 0);
    push("rst.fs", 5, 0);
    push_motors("rst", 0, 0, 0, 0);
    check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motor_arming_failsafe.md
# motor_arming_failsafe

Safety gate between `motor_mixer` and `pwm_generator`: passes the four motor rates only while the craft is armed and the receiver link is alive. Arming requires a held arm switch, low throttle, a good IMU and a live receiver. Disarming forces the motor outputs to zero at once. Receiver signal loss or IMU loss while armed ramps all motors down to zero, then locks out until the pilot resets the switch.

## Interface

Parameters:
- `RATE_WIDTH`, 8: motor rate width (0-250 scale).
- `ARM_HOLD_US`, 500000: µs the arm conditions must hold continuously before arming.
- `LOSS_TIMEOUT_US`, 100000: µs without a receiver pulse edge before the link is declared lost.
- `RAMP_STEP_US`, 10000: µs between 1-LSB decrements during failsafe ramp.
- `THROTTLE_ARM_MAX`, 10: maximum `throttle_val` allowed for arming.

Ports:
- `us_clk` in 1: 1 MHz clock, the only clock.
- `resetn` in 1: reset, synchronous to `us_clk`, active-low.
- `motor_1_rate_in` … `motor_4_rate_in` in RATE_WIDTH each: rates from the mixer.
- `throttle_val` in 8: receiver throttle value.
- `arm_switch` in 1: arm request, 1 = arm (`swa_swb_val[6]`).
- `rx_pulse` in 1: raw receiver throttle PWM, asynchronous.
- `imu_good` in 1: IMU ready.
- `motor_1_rate_out` … `motor_4_rate_out` out RATE_WIDTH each: gated rates to `pwm_generator`.
- `armed` out 1: high only in ARMED.
- `failsafe_active` out 1: high in RAMP and LOCKOUT.
- `signal_ok` out 1: receiver link alive.
- `state` out 3: current FSM state, for debug/UART.

## Operation

Receiver watchdog:
- `rx_pulse` passes through a 2-flop synchronizer.
- A rising edge after the synchronizer clears a µs counter. The counter otherwise increments and saturates at `LOSS_TIMEOUT_US`.
- `signal_ok` = counter < `LOSS_TIMEOUT_US`. After reset the counter is preloaded to saturation, so `signal_ok` = 0 until the first edge.

Arm condition: `arm_cond` = `arm_switch` & `signal_ok` & `imu_good` & (`throttle_val` <= `THROTTLE_ARM_MAX`).

FSM states and encodings:
- DISARMED (0): outputs 0. Moves to ARM_WAIT when `arm_cond`, hold counter cleared.
- ARM_WAIT (1): outputs 0. Hold counter increments each cycle. Returns to DISARMED the cycle `arm_cond` drops. Moves to ARMED when the counter reaches `ARM_HOLD_US`-1 with `arm_cond` still true.
- ARMED (2): outputs register the inputs each cycle.
  - `arm_switch` = 0 → DISARMED. Outputs are 0 on the next cycle.
  - Otherwise `signal_ok` = 0 or `imu_good` = 0 → RAMP. The current output values are held as the ramp start.
  - Throttle is not rechecked while ARMED.
- RAMP (3): inputs ignored. Every `RAMP_STEP_US` cycles each output decrements by 1, saturating at 0 independently.
  - When all four outputs are 0 → LOCKOUT.
  - `arm_switch` = 0 → DISARMED immediately with outputs 0.
  - Signal recovery does not end the ramp.
- LOCKOUT (4): outputs 0. Moves to DISARMED only when `arm_switch` = 0 and `signal_ok` = 1.
- Encodings 5-7 are illegal and recover to DISARMED with outputs 0.

Priority in ARMED when events coincide: switch-off disarm beats failsafe.

## Timing

- Reset state: DISARMED; all motor outputs 0; `armed` = 0; `failsafe_active` = 0; `signal_ok` = 0; `state` = 0; all counters cleared, watchdog saturated.
- Asserting reset mid-ramp or while armed forces the reset values on the next edge.
- ARMED passthrough latency: 1 cycle, input to output register.
- `rx_pulse` edge to `signal_ok` rise: 3 cycles.
- Link loss: `signal_ok` falls `LOSS_TIMEOUT_US` cycles after the last edge is detected. RAMP is entered 1 cycle later.
- Arming: ARMED is entered exactly `ARM_HOLD_US` cycles after entering ARM_WAIT.
- Ramp: the first decrement occurs `RAMP_STEP_US` cycles after entering RAMP. A start value V reaches 0 after V·`RAMP_STEP_US` cycles, and LOCKOUT follows 1 cycle later.
- `armed` and `failsafe_active` are registered and decoded from the next state, so they align with `state`.

## Test plan

Bench parameters: `ARM_HOLD_US`=20, `LOSS_TIMEOUT_US`=50, `RAMP_STEP_US`=4.

- Arm: toggle `rx_pulse` every 10 cycles, `imu_good`=1, throttle=5, `arm_switch`=1 held, inputs 100/110/120/130 → `armed` rises 20 cycles after ARM_WAIT entry; outputs follow the inputs 1 cycle later.
- Throttle abort: same stimulus but throttle rises to 50 at cycle 10 of ARM_WAIT → returns to DISARMED, outputs stay 0, `armed` never rises.
- Link loss: from ARMED with outputs 3/0/5/2, stop `rx_pulse` → RAMP after 50 cycles; outputs decrement every 4 cycles; all reach 0 after 20 cycles; LOCKOUT follows; `failsafe_active`=1 throughout.
- Lockout release: in LOCKOUT, restore pulses with `arm_switch`=1 → stays in LOCKOUT; set `arm_switch`=0 → DISARMED next cycle.
- Simultaneous events: in ARMED, drop `arm_switch` and `imu_good` on the same cycle → DISARMED, outputs 0 next cycle, `failsafe_active` stays 0.
- Reset mid-ramp: assert `resetn`=0 for 1 cycle during RAMP → all outputs 0, `state`=0, `signal_ok`=0 on the next edge.
